// File: rtl/spi_frame_builder.sv
// spi_frame_builder: debounced TX frame builder for the SPI slave, with RX command decode and link-loss timeout.
// Optional build macro: PRS_FRAME_PARITY_EN sets the frame LSB to odd parity. When it is undefined, the LSB is 0.
module spi_frame_builder #(
    parameter int DIN_BITS    = 12,
    parameter int DEB_CYCLES  = 16,
    parameter int TIMEOUT_CYC = 50000,
    parameter int TO_CNT_BITS = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DIN_BITS-1:0]   i_din,
    input  logic                  i_ssel_n,
    input  logic                  i_data_capt_st,
    input  logic [1:0]            i_RX_buff,
    output logic [DIN_BITS+3:0]   o_TX_buff,
    output logic                  o_ctrl,
    output logic                  o_flag_chg,
    output logic                  o_link_lost
);
    localparam int DC_BITS = $clog2(DEB_CYCLES);
    typedef enum logic [1:0] {IDLE, LOCKED, COMMIT} state_t;
    state_t state_q, state_d;
    logic [DIN_BITS-1:0] din_s1, din_s2, din_prev, din_deb;
    logic [DC_BITS-1:0] deb_cnt;
    logic [TO_CNT_BITS-1:0] to_cnt;
    logic [2:0] seq;
    logic ss_s1, ss_n, capt_prev, capt_seen, par;
    logic stable, accept, flag_set, done;
`ifdef PRS_FRAME_PARITY_EN
    assign par = ~^{seq, din_deb};
`else
    assign par = 1'b0;
`endif
    assign o_link_lost = to_cnt == TO_CNT_BITS'(TIMEOUT_CYC);
    always_comb begin
        state_d  = IDLE;
        stable   = din_s2 == din_prev;
        accept   = stable && deb_cnt == DC_BITS'(DEB_CYCLES - 1);
        flag_set = accept && din_s2 != din_deb;
        done     = state_q == COMMIT && capt_seen;
        case (state_q)
            IDLE:    state_d = ss_n ? IDLE : LOCKED;
            LOCKED:  state_d = ss_n ? COMMIT : LOCKED;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    // Select synchronizer resets to the idle (deselected) level so reset release never opens a transaction.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            din_s1     <= '0;
            din_s2     <= '0;
            din_prev   <= '0;
            din_deb    <= '0;
            deb_cnt    <= '0;
            to_cnt     <= '0;
            seq        <= '0;
            ss_s1      <= 1'b1;
            ss_n       <= 1'b1;
            capt_prev  <= 1'b0;
            capt_seen  <= 1'b0;
            o_TX_buff  <= '0;
            o_ctrl     <= 1'b0;
            o_flag_chg <= 1'b0;
        end else begin
            din_s1     <= i_din;
            din_s2     <= din_s1;
            din_prev   <= din_s2;
            ss_s1      <= i_ssel_n;
            ss_n       <= ss_s1;
            capt_prev  <= i_data_capt_st;
            deb_cnt    <= !stable ? '0 : accept ? deb_cnt : deb_cnt + 1'b1;
            din_deb    <= accept ? din_s2 : din_deb;
            o_flag_chg <= flag_set | (o_flag_chg & ~(done && i_RX_buff == 2'b01));
            to_cnt     <= done ? '0 : o_link_lost ? to_cnt : to_cnt + 1'b1;
            if (state_q == IDLE)
                o_TX_buff <= {seq, din_deb, par};
            if (state_q == LOCKED && i_data_capt_st && !capt_prev)
                capt_seen <= 1'b1;
            if (state_q == COMMIT)
                capt_seen <= 1'b0;
            if (done)
                seq <= i_RX_buff == 2'b11 ? 3'd0 : seq + 3'd1;
            if (done && i_RX_buff == 2'b10)
                o_ctrl <= ~o_ctrl;
        end
    end
endmodule

// File: tb/tb_spi_frame_builder.sv
// tb_spi_frame_builder: randomized self-checking bench for spi_frame_builder against a transaction-level model.
module tb_spi_frame_builder;
    logic clk = 1'b0, rst = 1'b1, ss = 1'b1, capt = 1'b0;
    logic [11:0] din = '0;
    logic [1:0] rx = '0;
    logic [15:0] tx;
    logic ctrl, flag, lost;
    int passed = 0, total = 0;
    logic [2:0] m_seq = '0;
    logic [11:0] m_deb = '0;
    logic m_ctrl = 1'b0, m_flag = 1'b0;

    spi_frame_builder #(.DIN_BITS(12), .DEB_CYCLES(16), .TIMEOUT_CYC(100), .TO_CNT_BITS(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_din(din), .i_ssel_n(ss), .i_data_capt_st(capt),
        .i_RX_buff(rx), .o_TX_buff(tx), .o_ctrl(ctrl), .o_flag_chg(flag), .o_link_lost(lost)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] frame(input logic [2:0] s, input logic [11:0] d);
`ifdef PRS_FRAME_PARITY_EN
        return {s, d, ~^{s, d}};
`else
        return {s, d, 1'b0};
`endif
    endfunction

    task automatic model_reset();
        m_seq = '0; m_deb = '0; m_ctrl = 1'b0; m_flag = 1'b0;
    endtask

    task automatic set_din(input logic [11:0] v);
        @(negedge clk); din = v;
        repeat (30) @(negedge clk);
        if (v != m_deb) m_flag = 1'b1;
        m_deb = v;
    endtask

    task automatic txn(input logic [1:0] r, input bit c, input bit chg, input logic [11:0] v);
        logic [15:0] exp_lock;
        @(negedge clk); ss = 1'b0;
        repeat (4) @(negedge clk);
        exp_lock = frame(m_seq, m_deb);
        total++;
        if (tx !== exp_lock) $display("FAIL lock_frame: got %h expected %h", tx, exp_lock); else passed++;
        if (chg) begin
            din = v;
            repeat (30) @(negedge clk);
            total++;
            if (tx !== exp_lock) $display("FAIL frozen_frame: got %h expected %h", tx, exp_lock); else passed++;
            if (v != m_deb) m_flag = 1'b1;
            m_deb = v;
        end
        rx = r; capt = c;
        repeat (2) @(negedge clk); ss = 1'b1;
        repeat (6) @(negedge clk); capt = 1'b0;
        if (c) begin
            if (r == 2'b01) m_flag = 1'b0;
            if (r == 2'b10) m_ctrl = ~m_ctrl;
            m_seq = r == 2'b11 ? 3'd0 : m_seq + 3'd1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (tx !== 16'h0) $display("FAIL rst_tx: got %h expected 0000", tx); else passed++;
        total++; if (ctrl !== 1'b0) $display("FAIL rst_ctrl: got %b expected 0", ctrl); else passed++;
        total++; if (flag !== 1'b0) $display("FAIL rst_flag: got %b expected 0", flag); else passed++;
        total++; if (lost !== 1'b0) $display("FAIL rst_lost: got %b expected 0", lost); else passed++;
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        total++; if (tx !== frame(3'd0, 12'h0)) $display("FAIL zero_frame_par: got %h expected %h", tx, frame(3'd0, 12'h0)); else passed++;
    endtask

    task automatic test_debounce();
        set_din(12'hA5C);
        total++; if (tx !== frame(m_seq, 12'hA5C)) $display("FAIL deb_accept: got %h expected %h", tx, frame(m_seq, 12'hA5C)); else passed++;
        total++; if (flag !== 1'b1) $display("FAIL deb_flag: got %b expected 1", flag); else passed++;
        for (int i = 0; i < 6; i++) begin
            din = din ^ 12'h001;
            repeat (8) @(negedge clk);
        end
        total++; if (tx !== frame(m_seq, 12'hA5C)) $display("FAIL deb_bounce: got %h expected %h", tx, frame(m_seq, 12'hA5C)); else passed++;
    endtask

    task automatic test_frozen();
        txn(2'b00, 1'b1, 1'b1, 12'h3C1);
        total++; if (tx !== frame(3'd1, 12'h3C1)) $display("FAIL commit_frame: got %h expected %h", tx, frame(3'd1, 12'h3C1)); else passed++;
        total++; if (flag !== m_flag) $display("FAIL commit_flag: got %b expected %b", flag, m_flag); else passed++;
    endtask

    task automatic test_commands();
        txn(2'b10, 1'b1, 1'b0, 12'h0);
        total++; if (ctrl !== 1'b1) $display("FAIL cmd_toggle: got %b expected 1", ctrl); else passed++;
        txn(2'b01, 1'b1, 1'b0, 12'h0);
        total++; if (flag !== 1'b0) $display("FAIL cmd_clear: got %b expected 0", flag); else passed++;
        // Commit lands on the same edge the debouncer accepts the new vector.
        @(negedge clk); ss = 1'b0;
        repeat (4) @(negedge clk); capt = 1'b1; rx = 2'b01;
        repeat (2) @(negedge clk);
        din = 12'h777;
        repeat (15) @(negedge clk); ss = 1'b1;
        repeat (10) @(negedge clk); capt = 1'b0;
        m_deb = 12'h777; m_flag = 1'b1; m_seq = m_seq + 3'd1;
        total++; if (flag !== 1'b1) $display("FAIL set_beats_clear: got %b expected 1", flag); else passed++;
        total++; if (tx !== frame(m_seq, m_deb)) $display("FAIL set_clear_frame: got %h expected %h", tx, frame(m_seq, m_deb)); else passed++;
    endtask

    task automatic test_seq_wrap();
        txn(2'b11, 1'b1, 1'b0, 12'h0);
        total++; if (tx[15:13] !== 3'd0) $display("FAIL seq_zero: got %0d expected 0", tx[15:13]); else passed++;
        for (int i = 0; i < 7; i++) txn(2'b00, 1'b1, 1'b0, 12'h0);
        total++; if (tx[15:13] !== 3'd7) $display("FAIL seq_seven: got %0d expected 7", tx[15:13]); else passed++;
        txn(2'b00, 1'b1, 1'b0, 12'h0);
        total++; if (tx[15:13] !== 3'd0) $display("FAIL seq_wrap: got %0d expected 0", tx[15:13]); else passed++;
        for (int i = 0; i < 5; i++) txn(2'b00, 1'b1, 1'b0, 12'h0);
        txn(2'b11, 1'b1, 1'b0, 12'h0);
        total++; if (tx[15:13] !== 3'd0) $display("FAIL seq_cmd_zero: got %0d expected 0", tx[15:13]); else passed++;
        txn(2'b00, 1'b0, 1'b0, 12'h0);
        total++; if (tx[15:13] !== 3'd0) $display("FAIL seq_abort: got %0d expected 0", tx[15:13]); else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            logic [1:0] r;
            logic [11:0] v;
            bit c, chg;
            r = 2'($urandom_range(0, 3));
            v = 12'($urandom);
            c = $urandom_range(0, 3) != 0;
            chg = $urandom_range(0, 1) == 1;
            if (!chg && $urandom_range(0, 1) == 1) set_din(v);
            txn(r, c, chg, v);
            total++; if (tx !== frame(m_seq, m_deb)) $display("FAIL rnd_frame[%0d]: got %h expected %h", i, tx, frame(m_seq, m_deb)); else passed++;
            total++; if (ctrl !== m_ctrl) $display("FAIL rnd_ctrl[%0d]: got %b expected %b", i, ctrl, m_ctrl); else passed++;
            total++; if (flag !== m_flag) $display("FAIL rnd_flag[%0d]: got %b expected %b", i, flag, m_flag); else passed++;
        end
    endtask

    task automatic test_timeout();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_reset();
        repeat (99) @(posedge clk);
        #1;
        total++; if (lost !== 1'b0) $display("FAIL lost_early: got %b expected 0", lost); else passed++;
        @(posedge clk);
        #1;
        total++; if (lost !== 1'b1) $display("FAIL lost_at_limit: got %b expected 1", lost); else passed++;
        if (din != m_deb) m_flag = 1'b1;
        m_deb = din;
        txn(2'b10, 1'b0, 1'b0, 12'h0);
        total++; if (lost !== 1'b1) $display("FAIL lost_abort: got %b expected 1", lost); else passed++;
        total++; if (ctrl !== 1'b0) $display("FAIL abort_ctrl: got %b expected 0", ctrl); else passed++;
        txn(2'b00, 1'b1, 1'b0, 12'h0);
        total++; if (lost !== 1'b0) $display("FAIL lost_cleared: got %b expected 0", lost); else passed++;
    endtask

    task automatic test_reset_mid();
        txn(2'b10, 1'b1, 1'b1, 12'h5A3);
        @(negedge clk); ss = 1'b0;
        repeat (5) @(negedge clk);
        #2 capt = 1'b0; rst = 1'b1;
        #1;
        total++; if (tx !== 16'h0) $display("FAIL mid_rst_tx: got %h expected 0000", tx); else passed++;
        total++; if (ctrl !== 1'b0) $display("FAIL mid_rst_ctrl: got %b expected 0", ctrl); else passed++;
        total++; if (flag !== 1'b0) $display("FAIL mid_rst_flag: got %b expected 0", flag); else passed++;
        @(negedge clk); rst = 1'b0;
        model_reset();
        repeat (30) @(negedge clk);
        total++; if (tx !== frame(3'd0, 12'h0)) $display("FAIL fresh_lock: got %h expected %h", tx, frame(3'd0, 12'h0)); else passed++;
        capt = 1'b1;
        repeat (2) @(negedge clk); ss = 1'b1;
        repeat (6) @(negedge clk); capt = 1'b0;
        m_deb = din; m_flag = din != 12'h0; m_seq = 3'd1;
        total++; if (tx !== frame(m_seq, m_deb)) $display("FAIL fresh_commit: got %h expected %h", tx, frame(m_seq, m_deb)); else passed++;
        total++; if (flag !== m_flag) $display("FAIL fresh_flag: got %b expected %b", flag, m_flag); else passed++;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_frozen();
        test_commands();
        test_seq_wrap();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
